// File: rtl/ctf_frame_tx.sv
// ctf_frame_tx: "$CTF" uplink frame encoder with 8N1 UART serialiser.
// Frame: 24 43 54 46 LEN CHAN DATA[LEN] CRC0 CRC1 FE, CRC-16/CCITT-FALSE over DATA.
// Ports:
//   clk, rst                  system clock, synchronous active-high reset
//   req_valid/ready/chan/len  frame request handshake
//   dat_valid/ready/byte      payload byte stream handshake
//   txd                       serial output, idle high
//   busy, frame_done          frame in progress, end-of-frame pulse
module ctf_frame_tx #(
    parameter int CLKS_PER_BIT = 69,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_chan,
    input  logic [7:0] req_len,
    input  logic       dat_valid,
    output logic       dat_ready,
    input  logic [7:0] dat_byte,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_H0   = 4'd1;
    localparam logic [3:0] S_H1   = 4'd2;
    localparam logic [3:0] S_H2   = 4'd3;
    localparam logic [3:0] S_H3   = 4'd4;
    localparam logic [3:0] S_LEN  = 4'd5;
    localparam logic [3:0] S_CHAN = 4'd6;
    localparam logic [3:0] S_DATA = 4'd7;
    localparam logic [3:0] S_CRC0 = 4'd8;
    localparam logic [3:0] S_CRC1 = 4'd9;
    localparam logic [3:0] S_ENDB = 4'd10;

    localparam logic [1:0] PH_START = 2'd0;
    localparam logic [1:0] PH_DATA  = 2'd1;
    localparam logic [1:0] PH_STOP  = 2'd2;

    logic [3:0]    state;
    logic [3:0]    nxt_state;
    logic [7:0]    len_q;
    logic [7:0]    chan_q;
    logic [7:0]    cnt;
    logic [15:0]   crc;
    logic [7:0]    crc_sh;
    logic [3:0]    crc_cnt;
    logic          crc_fb;
    logic          tx_act;
    logic [1:0]    ph;
    logic [BW-1:0] bcnt;
    logic [2:0]    bit_cnt;
    logic          stop_cnt;
    logic [7:0]    tx_byte;
    logic          req_fire;
    logic          dat_fire;
    logic          byte_end;
    logic          nxt_load;
    logic          ld;
    logic [7:0]    nxt_byte;
    logic [7:0]    ld_byte;

    assign req_ready = (state == S_IDLE);
    assign busy      = ~req_ready;
    // In DATA the serialiser is idle only while waiting for a payload byte.
    assign dat_ready = (state == S_DATA) && !tx_act;
    assign req_fire  = req_valid & req_ready;
    assign dat_fire  = dat_valid & dat_ready;
    assign byte_end  = tx_act && (ph == PH_STOP) &&
                       (bcnt == BAUD_MAX) && (stop_cnt == STOP_LAST);
    assign crc_fb    = crc[15] ^ crc_sh[7];

    always_comb begin
        txd = 1'b1;
        if (tx_act) begin
            case (ph)
                PH_START: txd = 1'b0;
                PH_DATA:  txd = tx_byte[bit_cnt];
                default:  txd = 1'b1;
            endcase
        end
    end

    // Successor of the current frame field and the byte it carries.
    always_comb begin
        nxt_state = S_IDLE;
        nxt_byte  = 8'hFE;
        case (state)
            S_H0: begin
                nxt_state = S_H1;
                nxt_byte  = 8'h43;
            end
            S_H1: begin
                nxt_state = S_H2;
                nxt_byte  = 8'h54;
            end
            S_H2: begin
                nxt_state = S_H3;
                nxt_byte  = 8'h46;
            end
            S_H3: begin
                nxt_state = S_LEN;
                nxt_byte  = len_q;
            end
            S_LEN: begin
                nxt_state = S_CHAN;
                nxt_byte  = chan_q;
            end
            S_CHAN, S_DATA: begin
                if ((state == S_CHAN) ? (len_q == 8'd0) : (cnt == 8'd0)) begin
                    nxt_state = S_CRC0;
                    nxt_byte  = crc[15:8];
                end else begin
                    nxt_state = S_DATA;
                end
            end
            S_CRC0: begin
                nxt_state = S_CRC1;
                nxt_byte  = crc[7:0];
            end
            S_CRC1: begin
                nxt_state = S_ENDB;
                nxt_byte  = 8'hFE;
            end
            default: begin
                nxt_state = S_IDLE;
                nxt_byte  = 8'hFE;
            end
        endcase
    end

    // Fixed fields chain back-to-back; DATA and IDLE leave the serialiser idle.
    assign nxt_load = (nxt_state != S_IDLE) && (nxt_state != S_DATA);
    assign ld       = req_fire | dat_fire | (byte_end & nxt_load);
    assign ld_byte  = req_fire ? 8'h24 : (dat_fire ? dat_byte : nxt_byte);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            len_q      <= 8'd0;
            chan_q     <= 8'd0;
            cnt        <= 8'd0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (req_fire) begin
                state  <= S_H0;
                len_q  <= req_len;
                chan_q <= req_chan;
                cnt    <= req_len;
            end else if (byte_end) begin
                state      <= nxt_state;
                frame_done <= (nxt_state == S_IDLE);
            end
            if (dat_fire) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_act   <= 1'b0;
            ph       <= PH_START;
            bcnt     <= '0;
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
            tx_byte  <= 8'hFF;
        end else if (ld) begin
            tx_act   <= 1'b1;
            ph       <= PH_START;
            bcnt     <= '0;
            bit_cnt  <= 3'd0;
            stop_cnt <= 1'b0;
            tx_byte  <= ld_byte;
        end else if (byte_end) begin
            tx_act <= 1'b0;
        end else if (tx_act) begin
            if (bcnt == BAUD_MAX) begin
                bcnt <= '0;
                case (ph)
                    PH_START: begin
                        ph      <= PH_DATA;
                        bit_cnt <= 3'd0;
                    end
                    PH_DATA: begin
                        if (bit_cnt == 3'd7) begin
                            ph       <= PH_STOP;
                            stop_cnt <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: stop_cnt <= 1'b1;
                endcase
            end else begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

    // Bit-serial CRC, one payload bit per clk, MSB first.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc     <= 16'hFFFF;
            crc_sh  <= 8'd0;
            crc_cnt <= 4'd0;
        end else if (req_fire) begin
            crc     <= 16'hFFFF;
            crc_cnt <= 4'd0;
        end else if (dat_fire) begin
            crc_sh  <= dat_byte;
            crc_cnt <= 4'd8;
        end else if (crc_cnt != 4'd0) begin
            crc     <= {crc[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
            crc_sh  <= {crc_sh[6:0], 1'b0};
            crc_cnt <= crc_cnt - 4'd1;
        end
    end
endmodule

// File: tb/tb_ctf_frame_tx.sv
// tb_ctf_frame_tx: directed bench for ctf_frame_tx.
// Decodes txd with a UART receiver and compares frames with expected bytes.
module tb_ctf_frame_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_chan = 8'd0;
    logic [7:0] req_len = 8'd0;
    logic       dat_valid = 1'b0;
    logic       dat_ready;
    logic [7:0] dat_byte = 8'd0;
    logic       txd;
    logic       busy;
    logic       frame_done;

    always #5 clk = ~clk;

    ctf_frame_tx #(
        .CLKS_PER_BIT(16),
        .STOP_BITS   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_chan  (req_chan),
        .req_len   (req_len),
        .dat_valid (dat_valid),
        .dat_ready (dat_ready),
        .dat_byte  (dat_byte),
        .txd       (txd),
        .busy      (busy),
        .frame_done(frame_done)
    );

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART receiver, 16 clk per bit, samples mid-bit on negedge.
    logic       rx_busy = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'd0;
    logic [7:0] rx_q[$];
    int         stop_err = 0;
    int         done_cnt = 0;
    int         dr_cnt = 0;

    always @(negedge clk) begin
        if (frame_done) done_cnt <= done_cnt + 1;
        if (dat_ready) dr_cnt <= dr_cnt + 1;
        if (rst) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (txd === 1'b0) begin
                rx_busy <= 1'b1;
                rx_cnt  <= 0;
            end
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= 23 && rx_cnt <= 135 && ((rx_cnt - 23) % 16) == 0)
                rx_sh <= {txd, rx_sh[7:1]};
            if (rx_cnt == 151) begin
                rx_busy <= 1'b0;
                rx_q.push_back(rx_sh);
                if (txd !== 1'b1) stop_err <= stop_err + 1;
            end
        end
    end

    logic [7:0] pay[$];
    logic [7:0] exp_q[$];
    int         rx_base = 0;
    int         done_base = 0;
    longint     acc_t = 0;
    longint     done_t = 0;
    longint     lat = 0;
    logic       gap_bad = 1'b0;

    function automatic logic [15:0] crc16();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (pay[i]) begin
            c = c ^ {pay[i], 8'h00};
            for (int b = 0; b < 8; b++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic build(input logic [7:0] ch, input logic [7:0] ln);
        logic [15:0] c;
        c = crc16();
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h46);
        exp_q.push_back(ln);
        exp_q.push_back(ch);
        foreach (pay[i]) exp_q.push_back(pay[i]);
        exp_q.push_back(c[15:8]);
        exp_q.push_back(c[7:0]);
        exp_q.push_back(8'hFE);
    endtask

    task automatic push_empty(input logic [7:0] ch);
        exp_q.push_back(8'h24);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h54);
        exp_q.push_back(8'h46);
        exp_q.push_back(8'h00);
        exp_q.push_back(ch);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFE);
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    task automatic check_frame(input string tag);
        chk({tag, "_nbytes"}, rx_q.size() - rx_base, exp_q.size());
        foreach (exp_q[i])
            chk($sformatf("%s_b%0d", tag, i), rx_at(rx_base + i), exp_q[i]);
    endtask

    task automatic start_test();
        rx_base   = rx_q.size();
        done_base = done_cnt;
        exp_q.delete();
        pay.delete();
    endtask

    task automatic do_req(input logic [7:0] ch, input logic [7:0] ln);
        int k;
        @(negedge clk);
        req_chan  = ch;
        req_len   = ln;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 4000) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready", req_ready, 1);
        @(posedge clk);
        acc_t = $time;
        #1;
        req_valid = 1'b0;
        req_chan  = 8'hEE;
        req_len   = 8'hEE;
        chk("busy_rise", busy, 1);
        chk("start_bit", txd, 0);
    endtask

    task automatic feed(input int n, input int stall_idx, input int stall_len);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!dat_ready && k < 6000);
            chk($sformatf("dat_ready_%0d", i), dat_ready, 1);
            if (!dat_ready) return;
            if (i == stall_idx) begin
                repeat (stall_len) begin
                    @(negedge clk);
                    if (txd !== 1'b1 || dat_ready !== 1'b1) gap_bad = 1'b1;
                end
            end
            dat_valid = 1'b1;
            dat_byte  = pay[i];
            @(posedge clk);
            #1;
            dat_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!frame_done && k < budget);
        chk("frame_done_seen", frame_done, 1);
        done_t = $time;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dr_base;
        repeat (3) @(negedge clk);
        chk("rst_txd", txd, 1);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_dat_ready", dat_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // 1: four payload bytes, no stalls
        start_test();
        pay = '{8'h35, 8'h47, 8'h65, 8'h78};
        build(8'h11, 8'h04);
        fork
            do_req(8'h11, 8'h04);
            feed(4, -1, 0);
        join
        wait_done(6000);
        lat = (done_t - 5 - acc_t) / 10;
        chk("t1_lat_lo", 32'(lat >= 2080), 1);
        chk("t1_lat_hi", 32'(lat <= 2084), 1);
        repeat (20) @(negedge clk);
        chk("t1_done_once", done_cnt - done_base, 1);
        check_frame("t1");

        // 2: "123456789" check value
        start_test();
        pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35,
                8'h36, 8'h37, 8'h38, 8'h39};
        build(8'h12, 8'h09);
        fork
            do_req(8'h12, 8'h09);
            feed(9, -1, 0);
        join
        wait_done(6000);
        repeat (20) @(negedge clk);
        chk("t2_crc0", rx_at(rx_base + 15), 8'h29);
        chk("t2_crc1", rx_at(rx_base + 16), 8'hB1);
        check_frame("t2");

        // 3: empty payload
        start_test();
        push_empty(8'h13);
        dr_base = dr_cnt;
        do_req(8'h13, 8'h00);
        wait_done(6000);
        repeat (20) @(negedge clk);
        chk("t3_no_dat_ready", dr_cnt - dr_base, 0);
        check_frame("t3");

        // 4: 500-cycle stall before second byte
        start_test();
        pay = '{8'hAA, 8'h55};
        build(8'h16, 8'h02);
        gap_bad = 1'b0;
        fork
            do_req(8'h16, 8'h02);
            feed(2, 1, 500);
        join
        wait_done(6000);
        repeat (20) @(negedge clk);
        chk("t4_gap_idle", gap_bad, 0);
        check_frame("t4");

        // 5: reset during third payload byte, then a fresh frame
        start_test();
        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        fork
            do_req(8'h17, 8'h06);
            feed(3, -1, 0);
        join
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_rst_txd", txd, 1);
        chk("t5_rst_ready", req_ready, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_dat_ready", dat_ready, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        start_test();
        pay = '{8'hC0, 8'hC1, 8'hC2};
        build(8'h18, 8'h03);
        fork
            do_req(8'h18, 8'h03);
            feed(3, -1, 0);
        join
        wait_done(6000);
        repeat (20) @(negedge clk);
        chk("t5_done_once", done_cnt - done_base, 1);
        check_frame("t5");

        // 6: req_valid held high across two frames
        start_test();
        push_empty(8'h14);
        push_empty(8'h15);
        @(negedge clk);
        req_chan  = 8'h14;
        req_len   = 8'h00;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_chan = 8'h15;
        wait_done(6000);
        chk("t6_ready_in_done", req_ready, 1);
        @(posedge clk);
        #1;
        chk("t6_busy_again", busy, 1);
        chk("t6_start_bit", txd, 0);
        req_valid = 1'b0;
        wait_done(6000);
        repeat (20) @(negedge clk);
        chk("t6_done_twice", done_cnt - done_base, 2);
        check_frame("t6");

        chk("stop_bits", stop_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ctf_frame_tx.md
Name: ctf_frame_tx

Overview:
- Uplink frame encoder and UART transmitter; the return direction of the CPU-to-FPGA "$CTF" frame link.
- Takes a channel number, a payload length and a payload byte stream from one of the 20 sub-UART channel buffers.
- Builds the frame: "$CTF" header, LEN, CHAN, DATA[LEN], CRC0, CRC1, 0xFE.
- Serialises the frame 8N1 on the FPGA-to-CPU serial line.

Parameters:
CLKS_PER_BIT, 69, clk cycles per UART bit (8 MHz / 115200); must be >= 16
STOP_BITS, 1, number of stop bits (1 or 2)

Ports:
clk  input  1  system clock (8 MHz)
rst  input  1  synchronous reset, active-high
req_valid  input  1  frame request
req_ready  output  1  high when a request can be accepted
req_chan  input  8  channel byte placed in the CHAN field (e.g. 0x11..0x24)
req_len  input  8  payload length in bytes, 0..255
dat_valid  input  1  payload byte available
dat_ready  output  1  encoder takes the payload byte this cycle
dat_byte  input  8  payload byte
txd  output  1  serial output; idle high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the last stop bit of 0xFE

Behaviour:
- Reset values (rst high at a clk edge): txd=1, req_ready=1, dat_ready=0, busy=0, frame_done=0. Frame FSM goes to IDLE and any frame in flight is dropped immediately; txd returns high in the same cycle.
- Request handshake:
  - Transfer occurs when req_valid & req_ready; chan and len are latched.
  - req_ready = (state==IDLE).
  - busy rises the cycle after the transfer.
  - Start bit of 0x24 begins the cycle after the transfer (1-cycle latency).
- Frame FSM states: IDLE -> H0(0x24) -> H1(0x43) -> H2(0x54) -> H3(0x46) -> LEN -> CHAN -> DATA -> CRC0 -> CRC1 -> ENDB(0xFE) -> IDLE.
  - CHAN goes directly to CRC0 when len==0.
  - DATA repeats until len bytes are sent; the byte counter is 8-bit and counts down.
- Byte serialiser:
  - Sequence per byte: start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clk.
  - A byte occupies (9+STOP_BITS)*CLKS_PER_BIT cycles.
  - Header, LEN, CHAN, CRC and END bytes are sent back-to-back with no idle gap.
- Payload handshake:
  - In DATA, when the serialiser needs the next byte (start of frame DATA phase, or the cycle after the previous byte's last stop bit), dat_ready=1.
  - The byte transfers on dat_valid & dat_ready, and its start bit begins the next cycle.
  - If dat_valid=0, dat_ready stays high and txd idles high (inter-byte gap allowed, unbounded).
  - dat_ready is 0 in every other state.
- CRC:
  - CRC-16/CCITT-FALSE: poly 0x1021, init 0xFFFF, MSB-first, no final XOR.
  - Covers payload bytes only.
  - Reinitialised at request accept.
  - Updated bit-serially over 8 clk after each payload byte transfer; this completes well before the byte finishes serialising, given CLKS_PER_BIT>=16.
  - CRC0 = CRC[15:8], CRC1 = CRC[7:0].
- frame_done: pulses 1 cycle at the return to IDLE. busy falls and req_ready rises in that same cycle. A new request is accepted in that cycle at the earliest.
- req_valid while busy is ignored (no queueing). req_chan and req_len changes after acceptance have no effect.
- Width rules:
  - Bit counter 0..7, counting LSB first.
  - Baud counter width = clog2(CLKS_PER_BIT); wraps at CLKS_PER_BIT-1.
  - len=255 sends 255 payload bytes without overflow.

Test Plan:
1. CLKS_PER_BIT=16, req chan=0x11 len=4 data 35 47 65 78 -> txd decodes 24 43 54 46 04 11 35 47 65 78 CRC0 CRC1 FE. CRC matches the reference model. frame_done pulses once, 13*160 cycles after accept with no data stalls.
2. Req chan=0x12 len=9 data 31..39 ("123456789") -> CRC0=0x29, CRC1=0xB1.
3. Req len=0 chan=0x13 -> 24 43 54 46 00 13 FF FF FE. dat_ready never asserted.
4. len=2 with dat_valid held low 500 cycles before byte 2 -> txd high throughout the gap, byte 2 is correct, CRC is unaffected.
5. rst asserted mid-DATA (byte 3 of 6), then a new request -> txd=1 and req_ready=1 the cycle after rst. The new frame is complete and correct, with CRC init 0xFFFF.
6. req_valid held high continuously, two back-to-back requests -> the second is accepted exactly in the frame_done cycle. The second header start bit follows in the next cycle.
